// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO on the UART transmit path.
// OS writes are absorbed into a DEPTH-entry ring buffer and replayed one
// byte at a time to the UART controller. Each byte gets a one-cycle
// write_nic strobe. The FSM then waits for nic_busy to rise, and then to fall.
// If nic_busy never rises within BUSY_TMO cycles, the byte is abandoned.
// A sticky overflow flag records writes that were lost while full.
// Optional feature macro: UART_TX_FIFO_STATS_EN adds drop/sent/timeout counters.
//
// Handshake: wr_en is a fire-and-forget valid with no ready. A write
// presented while full is dropped and flagged in overflow. Toward the
// controller, write_nic is a single-cycle valid. The controller signals
// acceptance by raising nic_busy, and completion by lowering it.
module uart_tx_fifo #(
  parameter int DEPTH    = 8,
  parameter int BUSY_TMO = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   clear_overflow,
  input  logic                   nic_busy,
  output logic                   write_nic,
  output logic [7:0]             data_to_nic,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
`ifdef UART_TX_FIFO_STATS_EN
  output logic [7:0]             drop_count,
  output logic [7:0]             sent_count,
  output logic [7:0]             tmo_count,
`endif
  output logic [1:0]             state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          write_nic_q, write_nic_d;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    mem_q [DEPTH];

  logic full_w;
  logic push;
  logic drop;
  logic pop;
  logic busy_seen;
  logic tmo_hit;

  assign full_w    = (count_q == DEPTH_C);
  assign push      = wr_en & ~full_w;
  assign drop      = wr_en & full_w;
  assign busy_seen = (state_q == WAIT_BUSY) & nic_busy;
  assign tmo_hit   = (state_q == WAIT_BUSY) & ~nic_busy & (tmo_q == TMO_LAST);

  assign full        = full_w;
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign write_nic   = write_nic_q;
  assign data_to_nic = data_q;
  assign state_dbg   = state_q;

  // Transmit sequencer: decide next state and the registered strobe/data
  always_comb begin
    state_d     = state_q;
    write_nic_d = 1'b0;
    data_d      = data_q;
    tmo_d       = tmo_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = LOAD;
      end
      LOAD: begin
        data_d      = mem_q[rd_ptr_q];
        write_nic_d = 1'b1;
        pop         = 1'b1;
        tmo_d       = '0;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Timeout counter stops at TMO_LAST because the state is left there
        if (busy_seen)    state_d = WAIT_DONE;
        else if (tmo_hit) state_d = IDLE;
        else              tmo_d   = tmo_q + TW'(1);
      end
      WAIT_DONE: begin
        if (!nic_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ring pointers, occupancy and sticky overflow (set beats clear)
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = (overflow_q & ~clear_overflow) | drop;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push & ~pop)      count_d = count_q + (AW+1)'(1);
    else if (pop & ~push) count_d = count_q - (AW+1)'(1);
  end

  // Byte storage, no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      write_nic_q <= 1'b0;
      data_q      <= 8'h00;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      write_nic_q <= write_nic_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
    end
  end

`ifdef UART_TX_FIFO_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] sent_cnt_q, sent_cnt_d;
  logic [7:0] tmo_cnt_q,  tmo_cnt_d;

  // Statistics: drops and timeouts saturate, sent wraps
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    sent_cnt_d = sent_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF))   drop_cnt_d = drop_cnt_q + 8'd1;
    if (busy_seen)                       sent_cnt_d = sent_cnt_q + 8'd1;
    if (tmo_hit && (tmo_cnt_q != 8'hFF)) tmo_cnt_d  = tmo_cnt_q + 8'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 8'h00;
      sent_cnt_q <= 8'h00;
      tmo_cnt_q  <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
  assign sent_count = sent_cnt_q;
  assign tmo_count  = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a queue-based
// reference model and a per-cycle compare process.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 8;
  localparam int BUSY_TMO = 1024;
  localparam int AW       = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        clear_overflow = 1'b0;
  logic        busy_force = 1'b0;
  logic        resp_busy = 1'b0;
  logic        nic_busy;
  logic        write_nic;
  logic [7:0]  data_to_nic;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic [1:0]  state_dbg;
`ifdef UART_TX_FIFO_STATS_EN
  logic [7:0]  drop_count;
  logic [7:0]  sent_count;
  logic [7:0]  tmo_count;
`endif

  assign nic_busy = busy_force | resp_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TMO(BUSY_TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .clear_overflow (clear_overflow),
    .nic_busy       (nic_busy),
    .write_nic      (write_nic),
    .data_to_nic    (data_to_nic),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
`ifdef UART_TX_FIFO_STATS_EN
    .drop_count     (drop_count),
    .sent_count     (sent_count),
    .tmo_count      (tmo_count),
`endif
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- result bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- controller responder ----------------
  bit resp_en    = 1'b0;
  int resp_delay = 3;
  int resp_hold  = 10;

  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && rst && write_nic) begin
        repeat (resp_delay) @(negedge clk);
        resp_busy = 1'b1;
        repeat (resp_hold) @(negedge clk);
        resp_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Timeline model: bytes live in exp_q; a strobe is scheduled two edges
  // after the engine is free and data is waiting; the engine becomes free
  // again when busy falls or BUSY_TMO edges pass without busy.
  logic [7:0] exp_q[$];
  int   m_edge = 0;
  bit   m_idle = 1'b1;
  bit   m_wbusy = 1'b0;
  bit   m_wdone = 1'b0;
  int   m_load_at = -1;
  int   m_strobe_at = -1;
  bit   m_ovf = 1'b0;
  bit   m_wnic = 1'b0;
  logic [7:0] m_data = 8'h00;
  int   m_drop = 0;
  int   m_sent = 0;
  int   m_tmo  = 0;
  bit   m_was_full;
  bit   m_dropw;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_idle = 1'b1; m_wbusy = 1'b0; m_wdone = 1'b0;
      m_load_at = -1; m_ovf = 1'b0; m_wnic = 1'b0; m_data = 8'h00;
      m_drop = 0; m_sent = 0; m_tmo = 0;
    end else begin
      m_edge++;
      m_was_full = (exp_q.size() == DEPTH);
      m_wnic = 1'b0;
      if (m_wbusy) begin
        if (nic_busy) begin
          m_wbusy = 1'b0; m_wdone = 1'b1; m_sent = (m_sent + 1) % 256;
        end else if (m_edge - m_strobe_at == BUSY_TMO) begin
          m_wbusy = 1'b0; m_idle = 1'b1;
          if (m_tmo < 255) m_tmo++;
        end
      end else if (m_wdone && !nic_busy) begin
        m_wdone = 1'b0; m_idle = 1'b1;
      end
      if (m_load_at == m_edge) begin
        m_data = exp_q.pop_front();
        m_wnic = 1'b1; m_wbusy = 1'b1; m_strobe_at = m_edge; m_load_at = -1;
      end
      m_dropw = wr_en && m_was_full;
      if (wr_en && !m_was_full) exp_q.push_back(wr_data);
      if (m_dropw && m_drop < 255) m_drop++;
      m_ovf = (m_ovf && !clear_overflow) || m_dropw;
      if (m_idle && exp_q.size() > 0) begin
        m_idle = 1'b0; m_load_at = m_edge + 2;
      end
    end
  end

  // ---------------- per-cycle compare + strobe log ----------------
  logic [7:0] rx_log[$];
  bit prev_wnic = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      check("count",     count,    exp_q.size());
      check("empty",     empty,    exp_q.size() == 0);
      check("full",      full,     exp_q.size() == DEPTH);
      check("overflow",  overflow, m_ovf);
      check("write_nic", write_nic, m_wnic);
      check("data",      data_to_nic, m_data);
      check("no_double_strobe", write_nic & prev_wnic, 0);
`ifdef UART_TX_FIFO_STATS_EN
      check("drop_count", drop_count, m_drop);
      check("sent_count", sent_count, m_sent);
      check("tmo_count",  tmo_count,  m_tmo);
`endif
      if (write_nic) rx_log.push_back(data_to_nic);
      prev_wnic = write_nic;
    end else begin
      prev_wnic = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'(first + 8'(i));
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_strobe(output int at, input int budget);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (write_nic) begin
        at = cyc;
        return;
      end
    end
    check("wait_strobe_timeout", write_nic, 1);
  endtask

  task automatic wait_drained(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_idle && exp_q.size() == 0 && !nic_busy) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", done, 1);
    check("drained_empty", empty, 1);
  endtask

  // ---------------- directed sequence ----------------
  int t_n, t_s, t_s2, base, g;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_write_nic", write_nic, 0);
    check("rst_data", data_to_nic, 8'h00);
    rst = 1'b1;

    // 1: single byte, latency edge N -> strobe at edge N+2
    resp_en = 1'b1; resp_delay = 3; resp_hold = 10;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    t_n = cyc;
    check("t1_count_after_write", count, 1);
    check("t1_empty_after_write", empty, 0);
    wait_strobe(t_s, 20);
    check("t1_latency", t_s - t_n, 2);
    check("t1_data", data_to_nic, 8'hA5);
    check("t1_count_after_pop", count, 0);
    @(negedge clk);
    check("t1_single_cycle", write_nic, 0);
    wait_drained(100);

    // 2: engine parked in WAIT_DONE, fill to full, ninth write dropped
    resp_en = 1'b0; busy_force = 1'b1;
    write_burst(8'hEE, 1);
    wait_strobe(t_s, 20);
    check("t2_park_data", data_to_nic, 8'hEE);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 9) begin
        check("t2_full_at_8", full, 1);
        check("t2_count_8", count, 8);
        check("t2_no_ovf_yet", overflow, 0);
      end
      wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("t2_overflow_set", overflow, 1);
    check("t2_count_still_8", count, 8);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    check("t2_overflow_cleared", overflow, 0);
`ifdef UART_TX_FIFO_STATS_EN
    check("t2_drop_count", drop_count, 1);
`endif

    // 3: release controller, drain 01..08 in order, then 20 more across wrap
    base = rx_log.size();
    resp_en = 1'b1; resp_delay = 1; resp_hold = 3;
    busy_force = 1'b0;
    wait_drained(300);
    check("t3_drain_len", rx_log.size() - base, 8);
    for (int i = 0; i < 8 && base + i < rx_log.size(); i++)
      check("t3_order", rx_log[base + i], 8'(i + 1));
    base = rx_log.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      g = 0;
      while (exp_q.size() == DEPTH && g < 500) begin
        @(negedge clk);
        g++;
      end
      wr_en = 1'b1; wr_data = 8'(8'h30 + 8'(i));
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_drained(1000);
    check("t3_wrap_len", rx_log.size() - base, 20);
    for (int i = 0; i < 20 && base + i < rx_log.size(); i++)
      check("t3_wrap_order", rx_log[base + i], 8'(8'h30 + 8'(i)));

    // 4: no busy response -> timeout, next byte strobes BUSY_TMO+2 later
    resp_en = 1'b0;
    write_burst(8'hB1, 2);
    wait_strobe(t_s, 20);
    check("t4_first_data", data_to_nic, 8'hB1);
    repeat (100) @(negedge clk);
    resp_en = 1'b1; resp_delay = 2; resp_hold = 4;
    wait_strobe(t_s2, BUSY_TMO + 50);
    check("t4_tmo_spacing", t_s2 - t_s, BUSY_TMO + 2);
    check("t4_second_data", data_to_nic, 8'hB2);
    wait_drained(100);
`ifdef UART_TX_FIFO_STATS_EN
    check("t4_tmo_count", tmo_count, 1);
`endif

    // 5: write coinciding with LOAD pop at count=3
    resp_en = 1'b0; busy_force = 1'b1;
    write_burst(8'hC0, 1);
    wait_strobe(t_s, 20);
    write_burst(8'hC1, 3);
    check("t5_count_3", count, 3);
    base = rx_log.size();
    busy_force = 1'b0; resp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hC4;
    @(negedge clk);
    wr_en = 1'b0;
    check("t5_strobe_now", write_nic, 1);
    check("t5_data_c1", data_to_nic, 8'hC1);
    check("t5_count_stays_3", count, 3);
    wait_drained(200);
    check("t5_len", rx_log.size() - base, 4);
    for (int i = 0; i < 4 && base + i < rx_log.size(); i++)
      check("t5_order", rx_log[base + i], 8'(8'hC1 + 8'(i)));

    // 6: asynchronous reset in WAIT_DONE with 4 bytes queued
    resp_en = 1'b0; busy_force = 1'b1;
    write_burst(8'hD0, 1);
    wait_strobe(t_s, 20);
    write_burst(8'hD1, 4);
    check("t6_queued_4", count, 4);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_full", full, 0);
    check("t6_rst_write_nic", write_nic, 0);
    check("t6_rst_data", data_to_nic, 8'h00);
    check("t6_rst_overflow", overflow, 0);
`ifdef UART_TX_FIFO_STATS_EN
    check("t6_rst_drop", drop_count, 0);
    check("t6_rst_sent", sent_count, 0);
    check("t6_rst_tmo", tmo_count, 0);
`endif
    busy_force = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = rx_log.size();
    repeat (20) @(negedge clk);
    check("t6_no_strobe_after_rst", rx_log.size() - base, 0);
    check("t6_still_empty", empty, 1);
    resp_en = 1'b1; resp_delay = 0; resp_hold = 2;
    write_burst(8'hE7, 1);
    wait_strobe(t_s, 20);
    check("t6_new_data", data_to_nic, 8'hE7);
    wait_drained(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
